// File: rtl/histogram_eq_pkg.sv
// Shared state encoding and arithmetic helpers for the histogram-equalisation stage.
package histogram_eq_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_BUILD = 2'd2
  } state_e;

  function automatic int nbins(input int pix_w);
    return 1 << pix_w;
  endfunction

  // Unsigned add clamped to the all-ones value of a w-bit field.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int w);
    logic [32:0] sum;
    logic [32:0] max;
    sum = {1'b0, a} + {1'b0, b};
    max = (33'd1 << w) - 33'd1;
    return (sum > max) ? max[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/hist_dpram.sv
// Simple dual-port RAM: one write port, one registered read port (read returns old data on collision).
module hist_dpram #(
  parameter  int DEPTH = 256,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/histogram_eq_lut.sv
// Global histogram equaliser: bins frame N, builds a clipped/scaled CDF LUT in vertical
// blanking into the idle bank of a ping-pong LUT, and remaps frame N+1 through it.
module histogram_eq_lut
  import histogram_eq_pkg::*;
#(
  parameter int PIX_W       = 8,
  parameter int CNT_W       = 20,
  parameter int SCALE_MUL   = 54,
  parameter int SCALE_SHIFT = 16,
  parameter int CLIP_LIMIT  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_HSYNC,
  input  logic             i_VSYNC,
  input  logic             i_BLANK,
  input  logic [PIX_W-1:0] i_Y0,
  input  logic             i_bypass,
  output logic             H_SYNC,
  output logic             V_SYNC,
  output logic             BLANK,
  output logic [PIX_W-1:0] o_Y,
  output logic             o_lut_swap,
  output logic             o_overrun
);

  localparam int NBINS  = nbins(PIX_W);
  localparam int MUL_W  = (SCALE_MUL > 1) ? $clog2(SCALE_MUL + 1) : 1;
  localparam int PROD_W = CNT_W + MUL_W;
  localparam logic [PIX_W-1:0] PIX_MAX = '1;

  function automatic logic [CNT_W-1:0] clip_bin(input logic [CNT_W-1:0] h);
    if ((CLIP_LIMIT != 0) && (h > CNT_W'(CLIP_LIMIT))) return CNT_W'(CLIP_LIMIT);
    return h;
  endfunction

  function automatic logic [PIX_W-1:0] scale_sat(input logic [CNT_W-1:0] cdf);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(cdf) * PROD_W'(SCALE_MUL);
    prod = prod >> SCALE_SHIFT;
    if (prod > PROD_W'(NBINS - 1)) return PIX_MAX;
    return prod[PIX_W-1:0];
  endfunction

  state_e           state_q;
  logic [PIX_W-1:0] init_addr_q;
  logic [PIX_W-1:0] rd_addr_q;
  logic             rd_run_q;
  logic             vs_q;
  logic [CNT_W-1:0] cdf_q;
  logic             drain_q;
  logic             bank_q;
  logic             lut_valid_q;
  logic             overrun_q;
  logic             swap_q;

  logic             acc_vld_p0_q;
  logic [PIX_W-1:0] acc_addr_p0_q;
  logic             b_vld_p0_q, b_last_p0_q, b_vld_p1_q, b_last_p1_q;
  logic [PIX_W-1:0] b_addr_p0_q, b_addr_p1_q;
  logic             hit_q;
  logic [CNT_W-1:0] fwd_q;
  logic [PIX_W-1:0] y_p0_q;
  logic             pass_p0_q;
  logic [2:0]       sync_p0_q;

  logic             fall;
  logic             hist_we;
  logic [PIX_W-1:0] hist_waddr, hist_raddr;
  logic [CNT_W-1:0] hist_wdata, hist_rdata;
  logic [CNT_W-1:0] rd_base, acc_inc, clip_h, cdf_d;
  logic             lut_we;
  logic [PIX_W:0]   lut_waddr, lut_raddr;
  logic [PIX_W-1:0] lut_wdata, lut_rdata;

  assign fall = vs_q & ~i_VSYNC;

  // A write landing on the same edge as a read of that bin is invisible to the RAM read; use it instead.
  assign rd_base = hit_q ? fwd_q : hist_rdata;
  assign acc_inc = CNT_W'(sat_add(32'(rd_base), 32'd1, CNT_W));
  assign clip_h  = clip_bin(rd_base);
  assign cdf_d   = CNT_W'(sat_add(32'(cdf_q), 32'(clip_h), CNT_W));

  always_comb begin
    hist_we    = 1'b0;
    hist_waddr = '0;
    hist_wdata = '0;
    if (state_q == ST_INIT) begin
      hist_we    = 1'b1;
      hist_waddr = init_addr_q;
    end else if (acc_vld_p0_q) begin
      hist_we    = 1'b1;
      hist_waddr = acc_addr_p0_q;
      hist_wdata = acc_inc;
    end else if (b_vld_p0_q) begin
      hist_we    = 1'b1;
      hist_waddr = b_addr_p0_q;
    end
  end

  assign hist_raddr = rd_run_q ? rd_addr_q : i_Y0;

  assign lut_we    = b_vld_p1_q;
  assign lut_waddr = {~bank_q, b_addr_p1_q};
  assign lut_wdata = scale_sat(cdf_q);
  assign lut_raddr = {bank_q, i_Y0};

  hist_dpram #(.DEPTH(NBINS), .WIDTH(CNT_W)) u_hist (
    .clk     (clk),
    .we_i    (hist_we),
    .waddr_i (hist_waddr),
    .wdata_i (hist_wdata),
    .raddr_i (hist_raddr),
    .rdata_o (hist_rdata)
  );

  hist_dpram #(.DEPTH(2 * NBINS), .WIDTH(PIX_W)) u_lut (
    .clk     (clk),
    .we_i    (lut_we),
    .waddr_i (lut_waddr),
    .wdata_i (lut_wdata),
    .raddr_i (lut_raddr),
    .rdata_o (lut_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      init_addr_q <= '0;
      rd_addr_q   <= '0;
      rd_run_q    <= 1'b0;
      vs_q        <= 1'b0;
      cdf_q       <= '0;
      drain_q     <= 1'b0;
      bank_q      <= 1'b0;
      lut_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      swap_q      <= 1'b0;
    end else begin
      vs_q   <= i_VSYNC;
      swap_q <= 1'b0;
      case (state_q)
        ST_INIT: begin
          init_addr_q <= init_addr_q + 1'b1;
          if (init_addr_q == PIX_MAX) state_q <= ST_ACCUM;
        end
        ST_ACCUM: begin
          if (fall) begin
            state_q   <= ST_BUILD;
            rd_run_q  <= 1'b1;
            rd_addr_q <= '0;
            cdf_q     <= '0;
          end
        end
        ST_BUILD: begin
          if (i_BLANK) overrun_q <= 1'b1;
          if (rd_run_q) begin
            rd_addr_q <= rd_addr_q + 1'b1;
            if (rd_addr_q == PIX_MAX) rd_run_q <= 1'b0;
          end
          if (b_vld_p0_q) cdf_q <= cdf_d;
          if (b_vld_p1_q && b_last_p1_q) drain_q <= 1'b1;
          if (drain_q) begin
            drain_q     <= 1'b0;
            bank_q      <= ~bank_q;
            lut_valid_q <= 1'b1;
            swap_q      <= 1'b1;
            state_q     <= ST_ACCUM;
          end
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  // p0: RAM reads issued; p1: clip/accumulate and histogram write-back; p2: LUT write / output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_vld_p0_q <= 1'b0;
      b_vld_p0_q   <= 1'b0;
      b_last_p0_q  <= 1'b0;
      b_vld_p1_q   <= 1'b0;
      b_last_p1_q  <= 1'b0;
      hit_q        <= 1'b0;
      pass_p0_q    <= 1'b1;
      sync_p0_q    <= '0;
      H_SYNC       <= 1'b0;
      V_SYNC       <= 1'b0;
      BLANK        <= 1'b0;
      o_Y          <= '0;
    end else begin
      acc_vld_p0_q <= (state_q == ST_ACCUM) && i_BLANK;
      b_vld_p0_q   <= rd_run_q;
      b_last_p0_q  <= rd_run_q && (rd_addr_q == PIX_MAX);
      b_vld_p1_q   <= b_vld_p0_q;
      b_last_p1_q  <= b_last_p0_q;
      hit_q        <= hist_we && (hist_waddr == hist_raddr);
      pass_p0_q    <= i_bypass || !lut_valid_q;
      sync_p0_q    <= {i_HSYNC, i_VSYNC, i_BLANK};
      H_SYNC       <= sync_p0_q[2];
      V_SYNC       <= sync_p0_q[1];
      BLANK        <= sync_p0_q[0];
      o_Y          <= pass_p0_q ? y_p0_q : lut_rdata;
    end
  end

  always_ff @(posedge clk) begin
    acc_addr_p0_q <= i_Y0;
    b_addr_p0_q   <= rd_addr_q;
    b_addr_p1_q   <= b_addr_p0_q;
    fwd_q         <= hist_wdata;
    y_p0_q        <= i_Y0;
  end

  assign o_lut_swap = swap_q;
  assign o_overrun  = overrun_q;

endmodule
